// File: rtl/upsampler_pkg.sv
// Shared definitions for the upsampler: FSM encodings, width defaults,
// channel placement and the saturating gain helper.
package upsampler_pkg;

    localparam int DWIDTH_DEF  = 16;
    localparam int DDWIDTH_DEF = 2 * DWIDTH_DEF;

    // Channel index within a sample word, counted from the least significant slice
    localparam int RIGHT_CH = 0;
    localparam int LEFT_CH  = 1;

    localparam logic [1:0] I_IDLE = 2'd0;
    localparam logic [1:0] I_REQ  = 2'd1;
    localparam logic [1:0] I_REL  = 2'd2;

    localparam logic O_WAIT = 1'b0;
    localparam logic O_ACK  = 1'b1;

    // Signed left shift clamped to the signed range of a dw-bit channel.
    // Works at 64 bits so any legal dw + shift combination fits without overflow.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] ch,
        input int                 shift,
        input int                 dw
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        v  = ch <<< shift;
        hi = (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 32'sd1));
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_gain.sv
// Combinational per-channel saturating gain; one instance per stereo channel.
module sample_gain
    import upsampler_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int GAIN_SHIFT = 0
) (
    input  logic [DWIDTH-1:0] ch,
    output logic [DWIDTH-1:0] y
);

    logic signed [63:0] ext_s;
    logic signed [63:0] sat_s;
    logic               unused_hi_s;

    assign ext_s = 64'(signed'(ch));
    assign sat_s = sat_shift(ext_s, GAIN_SHIFT, DWIDTH);
    assign y     = sat_s[DWIDTH-1:0];
    // Upper bits only carry sign extension after the clamp
    assign unused_hi_s = ^sat_s[63:DWIDTH];

endmodule

// File: rtl/upsampler.sv
// Interpolating front end: fetches stereo samples over req/ack and feeds the
// filter L words per sample (sample then zeros or repeats), one sample prefetched.
module upsampler
    import upsampler_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int DDWIDTH    = 2 * DWIDTH,
    parameter int L          = 4,
    parameter int HOLD       = 0,
    parameter int GAIN_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               in_req,
    input  logic               in_ack,
    input  logic [DDWIDTH-1:0] in_data,
    input  logic               out_req,
    output logic               out_ack,
    output logic [DDWIDTH-1:0] out_data,
    output logic               starve
);

    localparam int PH_W = (L > 1) ? $clog2(L) : 1;

    logic [1:0]         istate_r;
    logic               ostate_r;
    logic [DDWIDTH-1:0] nxt_r;
    logic               nxt_valid_r;
    logic [DDWIDTH-1:0] cur_r;
    logic [PH_W-1:0]    phase_r;
    logic [DWIDTH-1:0]  gain_left_s;
    logic [DWIDTH-1:0]  gain_right_s;
    logic [DDWIDTH-1:0] gain_word_s;
    logic               cap_s;
    logic               pop_s;

    sample_gain #(
        .DWIDTH     (DWIDTH),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_gain_left (
        .ch (in_data[LEFT_CH*DWIDTH +: DWIDTH]),
        .y  (gain_left_s)
    );

    sample_gain #(
        .DWIDTH     (DWIDTH),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_gain_right (
        .ch (in_data[RIGHT_CH*DWIDTH +: DWIDTH]),
        .y  (gain_right_s)
    );

    assign gain_word_s = {gain_left_s, gain_right_s};
    assign cap_s = (istate_r == I_REQ) && in_ack;
    assign pop_s = (ostate_r == O_WAIT) && out_req && (phase_r == PH_W'(0)) && nxt_valid_r;

    // Prefetch buffer: filled by a capture, emptied by a phase-0 pop (never both at once)
    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_r       <= {DDWIDTH{1'b0}};
            nxt_valid_r <= 1'b0;
        end else if (cap_s) begin
            nxt_r       <= gain_word_s;
            nxt_valid_r <= 1'b1;
        end else if (pop_s) begin
            nxt_valid_r <= 1'b0;
        end else begin
            nxt_valid_r <= nxt_valid_r;
        end
    end

    // Source-side four-phase master; a lingering ack holds off the next request
    always_ff @(posedge clk) begin
        if (rst) begin
            istate_r <= I_IDLE;
            in_req   <= 1'b0;
        end else begin
            case (istate_r)
                I_IDLE: begin
                    if (!nxt_valid_r && !in_ack) begin
                        in_req   <= 1'b1;
                        istate_r <= I_REQ;
                    end
                end
                I_REQ: begin
                    if (in_ack) begin
                        in_req   <= 1'b0;
                        istate_r <= I_REL;
                    end
                end
                I_REL: begin
                    if (!in_ack) begin
                        istate_r <= I_IDLE;
                    end
                end
                default: begin
                    in_req   <= 1'b0;
                    istate_r <= I_IDLE;
                end
            endcase
        end
    end

    // Filter-side four-phase slave; phase advances when each word handshake completes
    always_ff @(posedge clk) begin
        if (rst) begin
            ostate_r <= O_WAIT;
            out_ack  <= 1'b0;
            out_data <= {DDWIDTH{1'b0}};
            starve   <= 1'b0;
            phase_r  <= {PH_W{1'b0}};
            cur_r    <= {DDWIDTH{1'b0}};
        end else begin
            case (ostate_r)
                O_WAIT: begin
                    if (!out_req) begin
                        starve <= 1'b0;
                    end else if (phase_r != PH_W'(0)) begin
                        out_data <= (HOLD != 0) ? cur_r : {DDWIDTH{1'b0}};
                        out_ack  <= 1'b1;
                        starve   <= 1'b0;
                        ostate_r <= O_ACK;
                    end else if (nxt_valid_r) begin
                        cur_r    <= nxt_r;
                        out_data <= nxt_r;
                        out_ack  <= 1'b1;
                        starve   <= 1'b0;
                        ostate_r <= O_ACK;
                    end else begin
                        starve <= 1'b1;
                    end
                end
                O_ACK: begin
                    starve <= 1'b0;
                    if (!out_req) begin
                        out_ack  <= 1'b0;
                        phase_r  <= (phase_r == PH_W'(L - 1)) ? {PH_W{1'b0}} : phase_r + PH_W'(1);
                        ostate_r <= O_WAIT;
                    end
                end
                default: begin
                    out_ack  <= 1'b0;
                    starve   <= 1'b0;
                    ostate_r <= O_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upsampler.sv
// Self-checking bench: three upsampler configurations, table vectors, directed
// starve/reset sequences and randomized traffic against an arithmetic model.
module tb_upsampler;

    localparam int WAIT_BOUND = 200;
    localparam int SEL_IN_REQ  = 0;
    localparam int SEL_OUT_ACK = 1;
    localparam int SEL_STARVE  = 2;

    logic        clk;
    logic        rst;
    logic [2:0]  in_ack;
    logic [2:0]  out_req;
    logic [31:0] in_data [3];
    wire  [2:0]  in_req;
    wire  [2:0]  out_ack;
    wire  [2:0]  starve;
    wire  [31:0] out_data [3];

    int total;
    int bad;

    typedef struct {
        int          inst;
        logic [31:0] sample;
        logic [31:0] exp_first;
        logic [31:0] exp_rest;
    } vec_t;

    vec_t vecs [6];

    // inst 0: L=4 zero-stuff; inst 1: L=3 hold; inst 2: L=4 zero-stuff, gain x4
    upsampler #(.DWIDTH(16), .L(4), .HOLD(0), .GAIN_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_req(in_req[0]), .in_ack(in_ack[0]), .in_data(in_data[0]),
        .out_req(out_req[0]), .out_ack(out_ack[0]), .out_data(out_data[0]), .starve(starve[0]));
    upsampler #(.DWIDTH(16), .L(3), .HOLD(1), .GAIN_SHIFT(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_req(in_req[1]), .in_ack(in_ack[1]), .in_data(in_data[1]),
        .out_req(out_req[1]), .out_ack(out_ack[1]), .out_data(out_data[1]), .starve(starve[1]));
    upsampler #(.DWIDTH(16), .L(4), .HOLD(0), .GAIN_SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_req(in_req[2]), .in_ack(in_ack[2]), .in_data(in_data[2]),
        .out_req(out_req[2]), .out_ack(out_ack[2]), .out_data(out_data[2]), .starve(starve[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int inst_l(input int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic int inst_hold(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int inst_gain(input int k);
        return (k == 2) ? 2 : 0;
    endfunction

    // Reference: multiply by 2^g and clamp to the 16-bit signed range
    function automatic logic [15:0] ch_gain(input logic [15:0] c, input int g);
        int v;
        v = int'($signed(c)) * (1 << g);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [31:0] model_word(input int k, input logic [31:0] s, input int p);
        logic [31:0] g;
        g = {ch_gain(s[31:16], inst_gain(k)), ch_gain(s[15:0], inst_gain(k))};
        if (p == 0 || inst_hold(k) != 0) return g;
        return 32'h0;
    endfunction

    function automatic logic get_sig(input int sel, input int k);
        case (sel)
            SEL_IN_REQ:  return in_req[k];
            SEL_OUT_ACK: return out_ack[k];
            default:     return starve[k];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic wait_sig(input int sel, input int k, input logic val, input string name);
        for (int n = 0; n < WAIT_BOUND; n++) begin
            if (get_sig(sel, k) === val) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL timeout %s (inst %0d): signal never reached %b", name, k, val);
    endtask

    task automatic src_send(input int k, input logic [31:0] v, input int dly, input int linger);
        wait_sig(SEL_IN_REQ, k, 1'b1, "src_req_rise");
        repeat (dly) @(negedge clk);
        in_data[k] = v;
        in_ack[k]  = 1'b1;
        @(negedge clk);
        wait_sig(SEL_IN_REQ, k, 1'b0, "src_req_fall");
        for (int i = 0; i < linger; i++) begin
            @(negedge clk);
            chk1("linger_no_req", in_req[k], 1'b0);
        end
        in_ack[k]  = 1'b0;
        in_data[k] = 32'hDEAD_BEEF;
    endtask

    task automatic snk_get(input int k, input int gap, output logic [31:0] w);
        repeat (gap) @(negedge clk);
        out_req[k] = 1'b1;
        @(negedge clk);
        wait_sig(SEL_OUT_ACK, k, 1'b1, "snk_ack_rise");
        w = out_data[k];
        out_req[k] = 1'b0;
        @(negedge clk);
        wait_sig(SEL_OUT_ACK, k, 1'b0, "snk_ack_fall");
    endtask

    task automatic run_random(input int k, input int n);
        logic [31:0] samp [$];
        logic [31:0] expq [$];
        logic [31:0] s;
        for (int i = 0; i < n; i++) begin
            s = $urandom;
            if ($urandom_range(0, 1) == 1)
                s = {{3{s[31]}}, s[28:16], {3{s[15]}}, s[12:0]};
            samp.push_back(s);
            for (int p = 0; p < inst_l(k); p++) expq.push_back(model_word(k, s, p));
        end
        fork
            begin
                for (int i = 0; i < n; i++)
                    src_send(k, samp[i], $urandom_range(0, 5),
                             ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 2));
            end
            begin
                logic [31:0] w;
                for (int j = 0; j < n * inst_l(k); j++) begin
                    snk_get(k, $urandom_range(0, 3), w);
                    chk("rand_word", w, expq[j]);
                end
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        total = 0;
        bad   = 0;
        vecs[0] = '{0, 32'h0001FFFF, 32'h0001FFFF, 32'h00000000};
        vecs[1] = '{0, 32'h7FFF8000, 32'h7FFF8000, 32'h00000000};
        vecs[2] = '{1, 32'h00100020, 32'h00100020, 32'h00100020};
        vecs[3] = '{1, 32'h00300040, 32'h00300040, 32'h00300040};
        vecs[4] = '{2, 32'h01002000, 32'h04007FFF, 32'h00000000};
        vecs[5] = '{2, 32'hE000FF00, 32'h8000FC00, 32'h00000000};

        rst = 1'b1;
        in_ack = 3'b000;
        out_req = 3'b000;
        for (int k = 0; k < 3; k++) in_data[k] = 32'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk1("rst_in_req", in_req[k], 1'b0);
            chk1("rst_out_ack", out_ack[k], 1'b0);
            chk("rst_out_data", out_data[k], 32'h0);
            chk1("rst_starve", starve[k], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk1("first_req", in_req[k], 1'b1);

        for (int v = 0; v < 6; v++) begin
            fork
                src_send(vecs[v].inst, vecs[v].sample, 0, 0);
                begin
                    for (int p = 0; p < inst_l(vecs[v].inst); p++) begin
                        snk_get(vecs[v].inst, 0, w);
                        chk("table_word", w, (p == 0) ? vecs[v].exp_first : vecs[v].exp_rest);
                    end
                end
            join
        end

        // Starve: filter waits at phase 0 while the source stalls 20 cycles
        out_req[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("starve_wait_ack", out_ack[0], 1'b0);
            chk1("starve_wait_flag", starve[0], 1'b1);
        end
        in_data[0] = 32'h1234_5678;
        in_ack[0]  = 1'b1;
        @(negedge clk);
        chk1("starve_cap_req", in_req[0], 1'b0);
        chk1("starve_cap_flag", starve[0], 1'b1);
        chk1("starve_cap_ack", out_ack[0], 1'b0);
        in_ack[0] = 1'b0;
        @(negedge clk);
        chk1("starve_drop", starve[0], 1'b0);
        chk1("starve_ack_rise", out_ack[0], 1'b1);
        chk("starve_data", out_data[0], 32'h1234_5678);
        out_req[0] = 1'b0;
        @(negedge clk);
        wait_sig(SEL_OUT_ACK, 0, 1'b0, "starve_ack_fall");
        for (int p = 1; p < 4; p++) begin
            snk_get(0, 0, w);
            chk("starve_stuff", w, 32'h0);
        end

        run_random(2, 250);
        run_random(1, 40);

        // Reset in the middle of a phase-1 word with a fetch outstanding
        fork
            src_send(0, 32'hCAFE_0001, 0, 0);
            snk_get(0, 0, w);
        join
        chk("pre_rst_word", w, 32'hCAFE_0001);
        out_req[0] = 1'b1;
        @(negedge clk);
        wait_sig(SEL_OUT_ACK, 0, 1'b1, "pre_rst_ack");
        wait_sig(SEL_IN_REQ, 0, 1'b1, "pre_rst_req");
        chk1("pre_rst_ack_high", out_ack[0], 1'b1);
        rst = 1'b1;
        out_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk1("mid_rst_in_req", in_req[0], 1'b0);
        chk1("mid_rst_out_ack", out_ack[0], 1'b0);
        chk("mid_rst_out_data", out_data[0], 32'h0);
        chk1("mid_rst_starve", starve[0], 1'b0);
        chk1("mid_rst_in_req_1", in_req[1], 1'b0);
        fork
            src_send(0, 32'h0BAD_F00D, 0, 0);
            begin
                for (int p = 0; p < 4; p++) begin
                    snk_get(0, 0, w);
                    chk("post_rst_word", w, (p == 0) ? 32'h0BAD_F00D : 32'h0);
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
